// File: rtl/sap_datapath_if.sv
// Signal bundle between the SAP control sequencer (master) and the register/bus datapath (slave).
// Carries the 12-bit control word, the RAM load port and the datapath status/observation outputs.
interface sap_datapath_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic [11:0]       ctrl;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic [3:0]        opcode;
  logic [DATA_W-1:0] bus;
  logic [DATA_W-1:0] a_out;
  logic              flag_c;
  logic              flag_z;
  logic              halted;
  logic              bus_conflict;

  modport master (
    output ctrl, prog_we, prog_addr, prog_data,
    input  opcode, bus, a_out, flag_c, flag_z, halted, bus_conflict
  );

  modport slave (
    input  ctrl, prog_we, prog_addr, prog_data,
    output opcode, bus, a_out, flag_c, flag_z, halted, bus_conflict
  );
endinterface

// File: rtl/sap_datapath.sv
// SAP-1 style datapath: shared bus mux, PC/MAR/IR/A/B registers, adder/subtractor, program RAM,
// sticky halt and sticky bus-conflict latches. Driven cycle by cycle by the sequencer's control word.
module sap_datapath #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  sap_datapath_if.slave dp
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef struct packed {
    logic hlt;
    logic pc_inc;
    logic pc_en;
    logic mar_load;
    logic mem_en;
    logic ir_load;
    logic ir_en;
    logic a_load;
    logic a_en;
    logic b_load;
    logic adder_sub;
    logic adder_en;
  } ctrl_t;

  ctrl_t cw;
  assign cw = ctrl_t'(dp.ctrl);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] mar_q;
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              flag_c_q;
  logic              flag_z_q;
  logic              halted_q;
  logic              conflict_q;
  logic              run_q;

  logic [DATA_W-1:0] ram_q [DEPTH];

  logic [DATA_W-1:0] b_operand;
  logic [DATA_W:0]   alu_sum;
  logic [DATA_W-1:0] ram_rd;
  logic [DATA_W-1:0] bus_val;
  logic [4:0]        drivers;
  logic              multi_drv;
  logic              active;
  logic              capture;

  // Subtract is A + ~B + 1, so the carry-out doubles as "no borrow".
  assign b_operand = cw.adder_sub ? ~b_q : b_q;
  assign alu_sum   = {1'b0, a_q} + {1'b0, b_operand} + {{DATA_W{1'b0}}, cw.adder_sub};

  assign ram_rd = ram_q[mar_q];

  always_comb begin
    bus_val = '0;
    if (cw.mem_en) begin
      bus_val = ram_rd;
    end else if (cw.adder_en) begin
      bus_val = alu_sum[DATA_W-1:0];
    end else if (cw.a_en) begin
      bus_val = a_q;
    end else if (cw.ir_en) begin
      bus_val = {{(DATA_W-ADDR_W){1'b0}}, ir_q[ADDR_W-1:0]};
    end else if (cw.pc_en) begin
      bus_val = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
    end
  end

  // More than one bit set <=> clearing the lowest set bit leaves something behind.
  assign drivers   = {cw.mem_en, cw.adder_en, cw.a_en, cw.ir_en, cw.pc_en};
  assign multi_drv = |(drivers & (drivers - 5'd1));

  // run_q holds off the first edge after reset release so updates start on the second posedge.
  assign capture = run_q && !dp.prog_we;
  assign active  = capture && !halted_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= '0;
      mar_q      <= '0;
      ir_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      flag_c_q   <= 1'b0;
      flag_z_q   <= 1'b0;
      halted_q   <= 1'b0;
      conflict_q <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (active) begin
        if (cw.pc_inc) begin
          pc_q <= pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
        if (cw.mar_load) begin
          mar_q <= bus_val[ADDR_W-1:0];
        end
        if (cw.ir_load) begin
          ir_q <= bus_val;
        end
        if (cw.a_load) begin
          a_q <= bus_val;
        end
        if (cw.b_load) begin
          b_q <= bus_val;
        end
        // Flags track arithmetic results only; a plain LDA leaves them alone.
        if (cw.a_load && cw.adder_en) begin
          flag_c_q <= alu_sum[DATA_W];
          flag_z_q <= (alu_sum[DATA_W-1:0] == '0);
        end
      end
      if (capture) begin
        if (cw.hlt) begin
          halted_q <= 1'b1;
        end
        if (multi_drv) begin
          conflict_q <= 1'b1;
        end
      end
    end
  end

  // Program RAM has no reset and accepts writes even while halted.
  always_ff @(posedge clk) begin
    if (dp.prog_we) begin
      ram_q[dp.prog_addr] <= dp.prog_data;
    end
  end

  assign dp.opcode       = ir_q[DATA_W-1 -: 4];
  assign dp.bus          = bus_val;
  assign dp.a_out        = a_q;
  assign dp.flag_c       = flag_c_q;
  assign dp.flag_z       = flag_z_q;
  assign dp.halted       = halted_q;
  assign dp.bus_conflict = conflict_q;
endmodule
